// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feeder.
//   N           matrix dimension of the array (3x3)
//   FRAME_LEN   cycles per issued frame (N data phases plus one zero phase)
//   PHASE_W     width of the frame phase counter
//   FIFO_DEPTH  number of matrix pairs buffered ahead of the active frame
//   LAST_PHASE  phase value on which the next frame is decided
//   feed_state_e  feeder FSM states
//   lane_skew()   cycles of delay applied to lane i
//   elem_idx()    flattened element index of [row][col] in a row-major matrix
package systolic_pkg;

    localparam int N          = 3;
    localparam int FRAME_LEN  = 4;
    localparam int PHASE_W    = 2;
    localparam int FIFO_DEPTH = 2;

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } feed_state_e;

    // Lane i enters the array i cycles late so that row/column wavefronts meet.
    function automatic int lane_skew(input int lane);
        return lane;
    endfunction

    function automatic int elem_idx(input int row, input int col);
        return row * N + col;
    endfunction

endpackage

// File: rtl/matrix_fifo2.sv
// Two-entry FIFO of matrix pairs sitting in front of the feeder FSM.
// full/empty come straight from registers, so a push is refused whenever the
// FIFO was full at the start of the cycle, even if a pop happens alongside.
// Ports:
//   CLK, RST  clock, synchronous active-high reset
//   push      write request (ignored while full)
//   pop       read request (ignored while empty)
//   wdata     entry to write
//   rdata     head entry (valid while !empty)
//   full      two entries held
//   empty     no entries held
module matrix_fifo2 #(
    parameter int WIDTH = 144
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    import systolic_pkg::*;

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             full_q;
    logic             empty_q;
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        push_ok = push & ~full_q;
        pop_ok  = pop & ~empty_q;
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_q <= ~wr_ptr_q;
            if (pop_ok)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
            full_q  <= (count_d == 2'(FIFO_DEPTH));
            empty_q <= (count_d == 2'd0);
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge CLK) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/systolic_feeder.sv
// Upstream feeder for the 3x3 systolic array multiplier. Accepts A/B matrix
// pairs over valid/ready, buffers two, and issues them as skewed row/column
// lanes in 4-cycle frames, followed by one zero drain frame once the queue
// runs dry.
// Ports:
//   CLK, RST    clock, synchronous active-high reset
//   in_valid    matrix pair offered
//   in_ready    FIFO not full (registered)
//   in_a, in_b  row-major matrices, element [r][c] at (r*3+c)*DATAWIDTN
//   start       array enable, high during data and drain frames
//   A0..A2      row lanes, lane i delayed i cycles
//   B0..B2      column lanes, lane j delayed j cycles
//   busy        FSM not idle
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no frame on the lanes, start=0, lanes 0
// ST_RUN   | data frame from the active register, phase 0..3
// ST_DRAIN | zero frame with start=1 to flush the array's valid pipeline
module systolic_feeder #(
    parameter int DATAWIDTN = 8,
    parameter int N         = 3
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N*N*DATAWIDTN-1:0]   in_a,
    input  logic [N*N*DATAWIDTN-1:0]   in_b,
    output logic                       start,
    output logic [DATAWIDTN-1:0]       A0,
    output logic [DATAWIDTN-1:0]       A1,
    output logic [DATAWIDTN-1:0]       A2,
    output logic [DATAWIDTN-1:0]       B0,
    output logic [DATAWIDTN-1:0]       B1,
    output logic [DATAWIDTN-1:0]       B2,
    output logic                       busy
);
    import systolic_pkg::*;

    localparam int W  = DATAWIDTN;
    localparam int MW = N * N * W;
    localparam int PW = 2 * MW;

    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [PW-1:0] fifo_rdata;
    logic [MW-1:0] head_a;
    logic [MW-1:0] head_b;

    feed_state_e          state_q;
    feed_state_e          state_d;
    logic [PHASE_W-1:0]   phase_q;
    logic [PHASE_W-1:0]   phase_d;
    logic [MW-1:0]        act_a_q;
    logic [MW-1:0]        act_b_q;
    logic [MW-1:0]        act_a_d;
    logic [MW-1:0]        act_b_d;

    // Un-skewed lane values for the current phase; lane 0 drives the outputs
    // directly, lanes 1 and 2 feed the skew registers.
    logic [W-1:0] lane_a_d [N];
    logic [W-1:0] lane_b_d [N];
    logic [W-1:0] lane_a_q [N];
    logic [W-1:0] lane_b_q [N];

    logic [W-1:0] a1_q;
    logic [W-1:0] a2_mid_q;
    logic [W-1:0] a2_q;
    logic [W-1:0] b1_q;
    logic [W-1:0] b2_mid_q;
    logic [W-1:0] b2_q;
    logic         start_q;
    logic         busy_q;

    matrix_fifo2 #(
        .WIDTH (PW)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (in_valid),
        .pop   (fifo_pop),
        .wdata ({in_b, in_a}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_a = fifo_rdata[MW-1:0];
    assign head_b = fifo_rdata[PW-1:MW];

    always_comb begin
        fifo_pop = 1'b0;
        state_d  = state_q;
        phase_d  = phase_q;
        act_a_d  = act_a_q;
        act_b_d  = act_b_q;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_RUN;
                    phase_d  = '0;
                    act_a_d  = head_a;
                    act_b_d  = head_b;
                end
            end
            default: begin
                if (phase_q == LAST_PHASE) begin
                    phase_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = ST_RUN;
                        act_a_d  = head_a;
                        act_b_d  = head_b;
                    end else if (state_q == ST_RUN) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end
        endcase

        // Lanes are computed from the next state so they register alongside it;
        // the last phase of a data frame and every drain/idle phase carry zeros.
        for (int i = 0; i < N; i++) begin
            lane_a_d[i] = '0;
            lane_b_d[i] = '0;
            if (state_d == ST_RUN && phase_d != LAST_PHASE) begin
                lane_a_d[i] = act_a_d[elem_idx(i, int'(phase_d)) * W +: W];
                lane_b_d[i] = act_b_d[elem_idx(int'(phase_d), i) * W +: W];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            act_a_q  <= '0;
            act_b_q  <= '0;
            for (int i = 0; i < N; i++) begin
                lane_a_q[i] <= '0;
                lane_b_q[i] <= '0;
            end
            a1_q     <= '0;
            a2_mid_q <= '0;
            a2_q     <= '0;
            b1_q     <= '0;
            b2_mid_q <= '0;
            b2_q     <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            act_a_q <= act_a_d;
            act_b_q <= act_b_d;
            for (int i = 0; i < N; i++) begin
                lane_a_q[i] <= lane_a_d[i];
                lane_b_q[i] <= lane_b_d[i];
            end
            // Skew chains keep shifting across frame boundaries so the tail of
            // one frame overlaps the head of the next.
            a1_q     <= lane_a_q[1];
            a2_mid_q <= lane_a_q[2];
            a2_q     <= a2_mid_q;
            b1_q     <= lane_b_q[1];
            b2_mid_q <= lane_b_q[2];
            b2_q     <= b2_mid_q;
            start_q  <= (state_d != ST_IDLE);
            busy_q   <= (state_d != ST_IDLE);
        end
    end

    assign in_ready = ~fifo_full;
    assign start    = start_q;
    assign busy     = busy_q;
    assign A0       = lane_a_q[0];
    assign A1       = a1_q;
    assign A2       = a2_q;
    assign B0       = lane_b_q[0];
    assign B1       = b1_q;
    assign B2       = b2_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: random and directed matrix pairs,
// compared every cycle against a frame-level reference model.
module tb_systolic_feeder;

    localparam int W  = 8;
    localparam int MW = 9 * W;

    logic          CLK = 1'b0;
    logic          RST;
    logic          in_valid;
    logic          in_ready;
    logic [MW-1:0] in_a;
    logic [MW-1:0] in_b;
    logic          start;
    logic          busy;
    logic [W-1:0]  A0, A1, A2, B0, B1, B2;

    systolic_feeder #(
        .DATAWIDTN (W),
        .N         (3)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .start    (start),
        .A0       (A0),
        .A1       (A1),
        .A2       (A2),
        .B0       (B0),
        .B1       (B1),
        .B2       (B2),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    int st_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] el(input logic [MW-1:0] m, input int r, input int c);
        return m[(r * 3 + c) * W +: W];
    endfunction

    function automatic logic [MW-1:0] rand_mat();
        logic [MW-1:0] m;
        for (int i = 0; i < 9; i++) m[i * W +: W] = W'($urandom);
        return m;
    endfunction

    // Reference model: a queue of accepted pairs and the frame on the lanes.
    // kind: 0 nothing issued, 1 data frame, 2 drain frame; pos = cycle in frame.
    typedef struct {
        logic [MW-1:0] a;
        logic [MW-1:0] b;
    } pair_t;

    pair_t        pend[$];
    pair_t        cur;
    int           kind = 0;
    int           pos  = 0;
    logic [W-1:0] ua[3], ub[3], ha1[3], ha2[3], hb1[3], hb2[3];

    always @(posedge CLK) begin : model
        bit    hs;
        pair_t np;
        if (RST) begin
            pend.delete();
            kind = 0;
            pos  = 0;
            for (int i = 0; i < 3; i++) begin
                ua[i] = '0; ub[i] = '0; ha1[i] = '0; ha2[i] = '0; hb1[i] = '0; hb2[i] = '0;
            end
        end else begin
            hs = in_valid && (pend.size() < 2);
            for (int i = 0; i < 3; i++) begin
                ha2[i] = ha1[i]; ha1[i] = ua[i];
                hb2[i] = hb1[i]; hb1[i] = ub[i];
            end
            if (kind == 0 || pos == 3) begin
                pos = 0;
                if (pend.size() > 0) begin
                    cur  = pend.pop_front();
                    kind = 1;
                end else if (kind == 1) begin
                    kind = 2;
                end else begin
                    kind = 0;
                end
            end else begin
                pos++;
            end
            if (hs) begin
                np.a = in_a;
                np.b = in_b;
                pend.push_back(np);
            end
            for (int i = 0; i < 3; i++) begin
                ua[i] = (kind == 1 && pos < 3) ? el(cur.a, i, pos) : '0;
                ub[i] = (kind == 1 && pos < 3) ? el(cur.b, pos, i) : '0;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("start",    32'(start),    32'(kind != 0));
            chk("busy",     32'(busy),     32'(kind != 0));
            chk("in_ready", 32'(in_ready), 32'(pend.size() < 2));
            chk("A0", 32'(A0), 32'(ua[0]));
            chk("A1", 32'(A1), 32'(ha1[1]));
            chk("A2", 32'(A2), 32'(ha2[2]));
            chk("B0", 32'(B0), 32'(ub[0]));
            chk("B1", 32'(B1), 32'(hb1[1]));
            chk("B2", 32'(B2), 32'(hb2[2]));
            if (start) st_cnt++;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Holds in_valid until the pair is taken; returns in the cycle after the handshake.
    task automatic offer(input logic [MW-1:0] a, input logic [MW-1:0] b);
        bit hs = 1'b0;
        int guard = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!hs && guard < 50) begin
            hs = in_ready;
            tick();
            guard++;
        end
        in_valid = 1'b0;
        chk("offer_accept", 32'(hs), 32'd1);
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((kind != 0 || pend.size() != 0 || busy) && g < 300) begin
            tick();
            g++;
        end
        chk("idle_reached", 32'(g < 300), 32'd1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MW-1:0] ma, mb, ident, ramp;
        RST      = 1'b1;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        repeat (3) @(posedge CLK);
        #1;
        RST    = 1'b0;
        chk_en = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_start",    32'(start),    32'd0);
        chk("rst_busy",     32'(busy),     32'd0);

        // Single pair: A = 1..9, B = identity.
        ramp  = '0;
        ident = '0;
        for (int i = 0; i < 9; i++) ramp[i * W +: W] = W'(i + 1);
        for (int i = 0; i < 3; i++) ident[(i * 3 + i) * W +: W] = W'(1);
        st_cnt = 0;
        offer(ramp, ident);
        tick();
        chk("t1_start", 32'(start), 32'd1);
        chk("t1_A0",    32'(A0),    32'd1);
        chk("t1_B0",    32'(B0),    32'd1);
        tick();
        tick();
        chk("t1_A2", 32'(A2), 32'd7);
        chk("t1_A1", 32'(A1), 32'd5);
        wait_idle();
        chk("t1_start_cycles", 32'(st_cnt), 32'd8);

        // Three pairs back to back: three data frames plus one drain, no gap.
        st_cnt = 0;
        for (int k = 0; k < 3; k++) offer(rand_mat(), rand_mat());
        wait_idle();
        chk("t2_start_cycles", 32'(st_cnt), 32'd16);

        // Random pairs with random gaps.
        for (int k = 0; k < 20; k++) begin
            offer(rand_mat(), rand_mat());
            repeat ($urandom_range(0, 6)) tick();
        end
        wait_idle();

        // Reset at RUN phase 1 with one pair still queued.
        offer(rand_mat(), rand_mat());
        offer(rand_mat(), rand_mat());
        tick();
        RST = 1'b1;
        tick();
        chk("t4_start", 32'(start), 32'd0);
        chk("t4_busy",  32'(busy),  32'd0);
        chk("t4_lanes", 32'({A0, A1, A2, B0}), 32'd0);
        chk("t4_lanes_b", 32'({B1, B2}), 32'd0);
        RST = 1'b0;
        tick();
        chk("t4_in_ready", 32'(in_ready), 32'd1);
        repeat (8) tick();
        chk("t4_busy_after", 32'(busy), 32'd0);

        // Pair pushed during drain phase 2 follows the drain without a gap.
        offer(rand_mat(), rand_mat());
        repeat (7) tick();
        ma = rand_mat();
        mb = rand_mat();
        offer(ma, mb);
        chk("t5_start_drain", 32'(start), 32'd1);
        tick();
        chk("t5_start_run", 32'(start), 32'd1);
        chk("t5_A0", 32'(A0), 32'(el(ma, 0, 0)));
        chk("t5_B0", 32'(B0), 32'(el(mb, 0, 0)));
        wait_idle();

        // All-0xFF operands pass through unchanged.
        offer({MW{1'b1}}, {MW{1'b1}});
        tick();
        chk("t6_A0", 32'(A0), 32'hFF);
        chk("t6_B0", 32'(B0), 32'hFF);
        wait_idle();

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
